mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The module SHALL use one clock, clk, and one asynchronous active-low reset, rst_n.
REQ-002 clk  input  1  stage clock, rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 mem_params  input  mem_params_t  from EX/MEM: rd_addr, rd_data (ALU result = effective address or result), mem_op, mem_data (store data).
REQ-005 mem_valid  input  1  mem_params holds a live instruction.
REQ-006 stall  output  1  combinational; holds EX/MEM and upstream stages while high.
REQ-007 dbus_req, dbus_we  output  1 each  data-bus request and write-enable.
REQ-008 dbus_addr  output  32  word-aligned address; dbus_be  output  4  byte enables; dbus_wdata  output  32  lane-replicated store data.
REQ-009 dbus_ack  input  1  one-cycle completion; dbus_rdata  input  32  sampled when dbus_ack is high.
REQ-010 wb_params  output  wb_params_t  registered MEM/WB: rd_addr, rd_data, rd_we.
REQ-011 wb_valid  output  1  registered; wb_params is live.
REQ-012 align_err  output  1  registered one-cycle pulse flagging a misaligned access.

Function
REQ-013 FSM states SHALL be IDLE and BUS.
REQ-014 In IDLE with mem_valid and mem_op = MEM_OP_NONE: next edge wb_valid=1, rd_data = mem_params.rd_data, rd_we = (rd_addr != 0); stall=0; latency 1 cycle.
REQ-015 In IDLE with mem_valid and an aligned load/store: stall=1 this cycle; next edge latch addr/be/wdata/we/op/rd_addr and enter BUS; wb_valid=0.
REQ-016 In BUS: dbus_req=1 with latched fields held stable until dbus_ack; stall = !dbus_ack.
REQ-017 On dbus_ack in BUS: next edge return to IDLE and wb_valid=1; a load writes extended data with rd_we=(rd_addr!=0); a store writes rd_we=0.
REQ-018 The ack cycle SHALL NOT accept a new instruction; the next one is evaluated in IDLE on the following cycle; minimum memory-op latency is 2 cycles (accept to wb_valid).
REQ-019 mem_op encodings: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-020 dbus_addr = {addr[31:2], 2'b00}; byte: be = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}; half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}; word: be = 4'b1111, wdata = data.
REQ-021 Load extraction SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-022 Misalignment (half with addr[0]=1, word with addr[1:0]!=0): no bus request, stall=0, next edge align_err=1, wb_valid=0, FSM stays IDLE.
REQ-023 dbus_ack outside BUS SHALL be ignored.
REQ-024 mem_valid=0 in IDLE: next edge wb_valid=0, align_err=0.

Reset
REQ-025 On rst_n low, asynchronously: FSM=IDLE, wb_valid=0, wb_params='0, align_err=0, dbus_req=0, dbus_we=0, dbus_be=0, dbus_addr=0, dbus_wdata=0; an outstanding BUS transaction is abandoned.

Structure
REQ-026 mem_op_e, mem_params_t, wb_params_t and the FSM state enum SHALL live in package types.
REQ-027 Store lane formatting and load extraction SHALL be one combinational sub-module, mem_lane_fmt.

Verification
REQ-028 mem_op=NONE, rd_addr=5, rd_data=0x1234 -> next cycle wb_valid=1, rd_data=0x1234, rd_we=1, no dbus_req.
REQ-029 LB addr=0x103, dbus_rdata=0x80FFFFFF, ack after 3 BUS cycles -> dbus_addr=0x100, be=1000, stall high for 4 cycles, wb rd_data=0xFFFFFF80.
REQ-030 SH addr=0x202, mem_data=0xABCD1234, immediate ack -> dbus_we=1, be=1100, wdata=0x12341234, wb_valid=1 with rd_we=0 two cycles after accept.
REQ-031 LW addr=0x301 -> no dbus_req, align_err pulse, wb_valid=0, stall=0.
REQ-032 rst_n low during BUS -> dbus_req drops without waiting for clk; after release an LHU addr=0x0 with rdata=0x0000FFFF returns 0x0000FFFF.
REQ-033 Back-to-back LW then NONE -> NONE accepted the cycle after ack, wb_valid on consecutive cycles.

Source files
------------

// File: rtl/types.sv
// Shared types for the MEM pipeline stage: memory-op encodings, stage
// payload structs, FSM state enum and small op-classification helpers.
package types;

  typedef enum logic [3:0] {
    MEM_OP_NONE,
    MEM_OP_LB,
    MEM_OP_LBU,
    MEM_OP_LH,
    MEM_OP_LHU,
    MEM_OP_LW,
    MEM_OP_SB,
    MEM_OP_SH,
    MEM_OP_SW
  } mem_op_e;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;   // ALU result: effective address or final result
    mem_op_e     mem_op;
    logic [31:0] mem_data;  // store data
  } mem_params_t;

  typedef struct packed {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we;
  } wb_params_t;

  typedef enum logic {
    IDLE,
    BUS
  } mem_state_e;

  function automatic logic is_load(input mem_op_e op);
    return op inside {MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW};
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return op inside {MEM_OP_SB, MEM_OP_SH, MEM_OP_SW};
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane logic: store enables/replication, alignment check,
// and load lane extraction with sign or zero extension.
module mem_lane_fmt
  import types::*;
(
  input  mem_op_e     st_op,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        misaligned,
  input  mem_op_e     ld_op,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  // NOTE: every output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    st_be      = '0;
    st_wdata   = '0;
    misaligned = 1'b0;
    case (st_op)
      MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
        st_be    = 4'b0001 << st_addr_lo;
        st_wdata = {4{st_data[7:0]}};
      end
      MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: begin
        st_be      = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{st_data[15:0]}};
        misaligned = st_addr_lo[0];
      end
      MEM_OP_LW, MEM_OP_SW: begin
        st_be      = 4'b1111;
        st_wdata   = st_data;
        misaligned = (st_addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

  // Aligned accesses only reach here, so a word load always sees a zero shift.
  assign shifted = rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = shifted;
    case (ld_op)
      MEM_OP_LB:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      MEM_OP_LBU: ld_data = {24'h0, shifted[7:0]};
      MEM_OP_LH:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      MEM_OP_LHU: ld_data = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes ALU results through, runs loads/stores over a
// single-outstanding data bus, and registers the MEM/WB payload.
module mem_stage
  import types::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  mem_params_t mem_params,
  input  logic        mem_valid,
  output logic        stall,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output wb_params_t  wb_params,
  output logic        wb_valid,
  output logic        align_err
);

  mem_state_e  state_q, state_d;
  mem_op_e     op_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  rd_addr_q;
  logic        is_mem;
  logic        misaligned;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] ld_data;

  assign is_mem = (mem_params.mem_op != MEM_OP_NONE);

  mem_lane_fmt u_lane_fmt (
    .st_op      (mem_params.mem_op),
    .st_addr_lo (mem_params.rd_data[1:0]),
    .st_data    (mem_params.mem_data),
    .st_be      (fmt_be),
    .st_wdata   (fmt_wdata),
    .misaligned (misaligned),
    .ld_op      (op_q),
    .ld_addr_lo (addr_lo_q),
    .rdata      (dbus_rdata),
    .ld_data    (ld_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // dbus_req decodes straight from the state flop, so reset drops it at once.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    dbus_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_valid && is_mem && !misaligned) begin
          stall   = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        dbus_req = 1'b1;
        stall    = !dbus_ack;
        if (dbus_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_params  <= '0;
      align_err  <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_be    <= '0;
      dbus_wdata <= '0;
      op_q       <= MEM_OP_NONE;
      addr_lo_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      wb_valid  <= 1'b0;
      align_err <= 1'b0;
      if (state_q == IDLE && mem_valid) begin
        if (!is_mem) begin
          wb_valid          <= 1'b1;
          wb_params.rd_addr <= mem_params.rd_addr;
          wb_params.rd_data <= mem_params.rd_data;
          wb_params.rd_we   <= (mem_params.rd_addr != 5'd0);
        end else if (misaligned) begin
          align_err <= 1'b1;
        end else begin
          dbus_we    <= is_store(mem_params.mem_op);
          dbus_addr  <= {mem_params.rd_data[31:2], 2'b00};
          dbus_be    <= fmt_be;
          dbus_wdata <= fmt_wdata;
          op_q       <= mem_params.mem_op;
          addr_lo_q  <= mem_params.rd_data[1:0];
          rd_addr_q  <= mem_params.rd_addr;
        end
      end else if (state_q == BUS && dbus_ack) begin
        wb_valid          <= 1'b1;
        wb_params.rd_addr <= rd_addr_q;
        wb_params.rd_data <= is_load(op_q) ? ld_data : 32'h0;
        wb_params.rd_we   <= is_load(op_q) && (rd_addr_q != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment,
// reset during a bus transaction and back-to-back issue.
module tb_mem_stage;
  import types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  mem_params_t mem_params;
  logic        mem_valid;
  logic        stall;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  wb_params_t  wb_params;
  logic        wb_valid;
  logic        align_err;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_params (mem_params),
    .mem_valid  (mem_valid),
    .stall      (stall),
    .dbus_req   (dbus_req),
    .dbus_we    (dbus_we),
    .dbus_addr  (dbus_addr),
    .dbus_be    (dbus_be),
    .dbus_wdata (dbus_wdata),
    .dbus_ack   (dbus_ack),
    .dbus_rdata (dbus_rdata),
    .wb_params  (wb_params),
    .wb_valid   (wb_valid),
    .align_err  (align_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1ns after the next rising edge; registered outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input mem_op_e op, input logic [31:0] addr,
                       input logic [4:0] rd, input logic [31:0] data);
    mem_valid           = 1'b1;
    mem_params.mem_op   = op;
    mem_params.rd_data  = addr;
    mem_params.rd_addr  = rd;
    mem_params.mem_data = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(MEM_OP_LW, 32'h0000_0040, 5'd1, 32'h0);
    #3;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL reset_idle_accept_stall: got %b want 1", stall); end
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    tests_run++; if (wb_params !== '0) begin tests_failed++; $display("FAIL reset_wb_params: got %h want 0", wb_params); end
    tests_run++; if (align_err !== 1'b0) begin tests_failed++; $display("FAIL reset_align_err: got %b want 0", align_err); end
    tests_run++; if ({dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata} !== '0) begin tests_failed++;
      $display("FAIL reset_dbus: req=%b we=%b be=%b addr=%h wdata=%h want all 0", dbus_req, dbus_we, dbus_be, dbus_addr, dbus_wdata); end
    step();
    tests_run++; if (dbus_req !== 1'b0) begin tests_failed++; $display("FAIL reset_held_no_req: got %b want 0", dbus_req); end
    mem_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    drive(MEM_OP_NONE, 32'h0000_1234, 5'd5, 32'h0);
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL none_stall: got %b want 0", stall); end
    tests_run++; if (dbus_req !== 1'b0) begin tests_failed++; $display("FAIL none_req: got %b want 0", dbus_req); end
    step();
    tests_run++; if (wb_valid !== 1'b1 || wb_params.rd_data !== 32'h1234 || wb_params.rd_we !== 1'b1 || wb_params.rd_addr !== 5'd5) begin
      tests_failed++; $display("FAIL none_wb: valid=%b rd=%0d data=%h we=%b want 1/5/00001234/1",
        wb_valid, wb_params.rd_addr, wb_params.rd_data, wb_params.rd_we); end
    drive(MEM_OP_NONE, 32'hDEAD_BEEF, 5'd0, 32'h0);
    step();
    tests_run++; if (wb_valid !== 1'b1 || wb_params.rd_data !== 32'hDEADBEEF || wb_params.rd_we !== 1'b0) begin
      tests_failed++; $display("FAIL none_x0_wb: valid=%b data=%h we=%b want 1/deadbeef/0", wb_valid, wb_params.rd_data, wb_params.rd_we); end
    mem_valid = 1'b0;
    dbus_ack  = 1'b1;
    step();
    dbus_ack  = 1'b0;
    tests_run++; if (wb_valid !== 1'b0 || align_err !== 1'b0 || dbus_req !== 1'b0) begin
      tests_failed++; $display("FAIL idle_stray_ack: valid=%b err=%b req=%b want 0/0/0", wb_valid, align_err, dbus_req); end
  endtask

  task automatic test_load_byte();
    int stall_cycles = 0;
    drive(MEM_OP_LB, 32'h0000_0103, 5'd9, 32'h0);
    dbus_rdata = 32'h80FF_FFFF;
    #1;
    if (stall) stall_cycles++;
    tests_run++; if (dbus_req !== 1'b0) begin tests_failed++; $display("FAIL lb_accept_req: got %b want 0", dbus_req); end
    for (int c = 0; c < 3; c++) begin
      step();
      if (stall) stall_cycles++;
      tests_run++; if (dbus_req !== 1'b1 || dbus_addr !== 32'h100 || dbus_be !== 4'b1000 || dbus_we !== 1'b0) begin
        tests_failed++; $display("FAIL lb_bus_c%0d: req=%b addr=%h be=%b we=%b want 1/100/1000/0", c, dbus_req, dbus_addr, dbus_be, dbus_we); end
    end
    step();
    dbus_ack = 1'b1;
    #1;
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lb_ack_stall: got %b want 0", stall); end
    tests_run++; if (stall_cycles != 4) begin tests_failed++; $display("FAIL lb_stall_cycles: got %0d want 4", stall_cycles); end
    step();
    dbus_ack  = 1'b0;
    mem_valid = 1'b0;
    tests_run++; if (wb_valid !== 1'b1 || wb_params.rd_data !== 32'hFFFFFF80 || wb_params.rd_we !== 1'b1 || wb_params.rd_addr !== 5'd9) begin
      tests_failed++; $display("FAIL lb_wb: valid=%b rd=%0d data=%h we=%b want 1/9/ffffff80/1",
        wb_valid, wb_params.rd_addr, wb_params.rd_data, wb_params.rd_we); end
    tests_run++; if (dbus_req !== 1'b0) begin tests_failed++; $display("FAIL lb_req_after_ack: got %b want 0", dbus_req); end
  endtask

  task automatic test_store_half();
    drive(MEM_OP_SH, 32'h0000_0202, 5'd6, 32'hABCD_1234);
    #1;
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL sh_accept_stall: got %b want 1", stall); end
    step();
    dbus_ack = 1'b1;
    #1;
    tests_run++; if (dbus_req !== 1'b1 || dbus_we !== 1'b1 || dbus_be !== 4'b1100 || dbus_wdata !== 32'h12341234 || dbus_addr !== 32'h200) begin
      tests_failed++; $display("FAIL sh_bus: req=%b we=%b be=%b wdata=%h addr=%h want 1/1/1100/12341234/200",
        dbus_req, dbus_we, dbus_be, dbus_wdata, dbus_addr); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL sh_ack_stall: got %b want 0", stall); end
    step();
    dbus_ack  = 1'b0;
    mem_valid = 1'b0;
    tests_run++; if (wb_valid !== 1'b1 || wb_params.rd_we !== 1'b0) begin
      tests_failed++; $display("FAIL sh_wb: valid=%b we=%b want 1/0", wb_valid, wb_params.rd_we); end
  endtask

  task automatic test_misaligned();
    drive(MEM_OP_LW, 32'h0000_0301, 5'd3, 32'h0);
    #1;
    tests_run++; if (stall !== 1'b0 || dbus_req !== 1'b0) begin
      tests_failed++; $display("FAIL lw_mis_accept: stall=%b req=%b want 0/0", stall, dbus_req); end
    step();
    drive(MEM_OP_LH, 32'h0000_0101, 5'd3, 32'h0);
    #1;
    tests_run++; if (align_err !== 1'b1 || wb_valid !== 1'b0 || dbus_req !== 1'b0 || stall !== 1'b0) begin
      tests_failed++; $display("FAIL lw_mis_pulse: err=%b valid=%b req=%b stall=%b want 1/0/0/0", align_err, wb_valid, dbus_req, stall); end
    step();
    mem_valid = 1'b0;
    tests_run++; if (align_err !== 1'b1 || dbus_req !== 1'b0) begin
      tests_failed++; $display("FAIL lh_mis_pulse: err=%b req=%b want 1/0", align_err, dbus_req); end
    step();
    tests_run++; if (align_err !== 1'b0 || wb_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mis_pulse_end: err=%b valid=%b want 0/0", align_err, wb_valid); end
  endtask

  task automatic test_reset_in_bus();
    drive(MEM_OP_LHU, 32'h0000_0000, 5'd7, 32'h0);
    dbus_rdata = 32'h0000_FFFF;
    step();
    tests_run++; if (dbus_req !== 1'b1) begin tests_failed++; $display("FAIL rst_bus_req: got %b want 1", dbus_req); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if (dbus_req !== 1'b0 || dbus_addr !== 32'h0 || dbus_be !== 4'b0) begin
      tests_failed++; $display("FAIL rst_async_drop: req=%b addr=%h be=%b want 0/0/0", dbus_req, dbus_addr, dbus_be); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++; if (stall !== 1'b1 || dbus_req !== 1'b0) begin
      tests_failed++; $display("FAIL rst_release_idle: stall=%b req=%b want 1/0", stall, dbus_req); end
    step();
    dbus_ack = 1'b1;
    #1;
    tests_run++; if (dbus_req !== 1'b1 || dbus_be !== 4'b0011) begin
      tests_failed++; $display("FAIL lhu_bus: req=%b be=%b want 1/0011", dbus_req, dbus_be); end
    step();
    dbus_ack  = 1'b0;
    mem_valid = 1'b0;
    tests_run++; if (wb_valid !== 1'b1 || wb_params.rd_data !== 32'h0000FFFF || wb_params.rd_we !== 1'b1) begin
      tests_failed++; $display("FAIL lhu_wb: valid=%b data=%h we=%b want 1/0000ffff/1", wb_valid, wb_params.rd_data, wb_params.rd_we); end
  endtask

  task automatic test_back_to_back();
    drive(MEM_OP_LW, 32'h0000_0400, 5'd3, 32'h0);
    dbus_rdata = 32'hCAFE_F00D;
    step();
    dbus_ack = 1'b1;
    step();
    dbus_ack = 1'b0;
    drive(MEM_OP_NONE, 32'h0000_0055, 5'd4, 32'h0);
    #1;
    tests_run++; if (wb_valid !== 1'b1 || wb_params.rd_data !== 32'hCAFEF00D || wb_params.rd_addr !== 5'd3) begin
      tests_failed++; $display("FAIL b2b_lw_wb: valid=%b rd=%0d data=%h want 1/3/cafef00d", wb_valid, wb_params.rd_addr, wb_params.rd_data); end
    tests_run++; if (stall !== 1'b0 || dbus_req !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_none_accept: stall=%b req=%b want 0/0", stall, dbus_req); end
    step();
    mem_valid = 1'b0;
    tests_run++; if (wb_valid !== 1'b1 || wb_params.rd_data !== 32'h55 || wb_params.rd_addr !== 5'd4 || wb_params.rd_we !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_none_wb: valid=%b rd=%0d data=%h we=%b want 1/4/00000055/1",
        wb_valid, wb_params.rd_addr, wb_params.rd_data, wb_params.rd_we); end
    step();
    tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %b want 0", wb_valid); end
  endtask

  initial begin
    mem_valid  = 1'b0;
    mem_params = '0;
    dbus_ack   = 1'b0;
    dbus_rdata = '0;
    test_reset();
    test_passthrough();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_reset_in_bus();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
